ps_frame_reader: RTL and testbench
==================================

Name: ps_frame_reader

Overview:
- Transmit end of the pixel-stream interface consumed by the filter tops (i_data/i_valid/o_ready on the filter side).
- Reads an 8-bit grayscale frame from a synchronous framebuffer RAM in raster order and presents it as a valid/ready stream, with frame and line sideband.
- Sits between the framebuffer and the first processing stage (for example, the Gaussian pipeline).

Parameters:
- DATA_W, 8, pixel width
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- BASE_ADDR, 0, framebuffer address of pixel (0,0)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  one-cycle pulse; begin reading one frame
- o_busy  out  1  high from accepted start until the last pixel is transferred
- o_done  out  1  one-cycle pulse after the final pixel is transferred
- o_rd_en  out  1  RAM read enable
- o_rd_addr  out  ADDR_W  RAM read address
- i_rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after o_rd_en
- o_data  out  DATA_W  stream pixel
- o_valid  out  1  stream valid
- i_ready  in  1  downstream ready
- o_sof  out  1  qualifies o_data: first pixel of the frame
- o_eol  out  1  qualifies o_data: last pixel of a line
- o_eof  out  1  qualifies o_data: last pixel of the frame

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - all outputs 0; o_rd_addr = BASE_ADDR
  - FSM to IDLE; FIFO emptied
  - a RAM read in flight at reset is discarded; its data is never pushed
  - reset mid-frame aborts the frame with no o_done
- FSM:
  - IDLE: i_start -> FETCH. Load x=0, y=0, rd_addr=BASE_ADDR. o_busy rises the next cycle.
  - FETCH: issue reads. After issuing the read for (H_ACTIVE-1, V_ACTIVE-1) -> DRAIN.
  - DRAIN: wait until FIFO is empty and no read is in flight -> DONE.
  - DONE: o_done=1 for one cycle, o_busy=0 -> IDLE.
  - i_start is ignored outside IDLE.
- Read issue:
  - Internal 2-entry FIFO holds {pixel, sof, eol, eof}. One in-flight flag tracks the 1-cycle RAM latency.
  - Issue (o_rd_en=1) in FETCH when occ + inflight - pop < 2, where pop = o_valid & i_ready in the same cycle.
  - This sustains 1 pixel/clk with i_ready held high.
  - Each issue advances x. At x=H_ACTIVE-1, x wraps to 0 and y increments. rd_addr increments by 1.
  - Sideband flags are computed from (x,y) at issue time and travel with the read (delayed 1 cycle) into the FIFO.
- Stream handshake:
  - o_valid = FIFO not empty. o_data and sideband come from the FIFO head.
  - Transfer occurs when o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_data and flags are held stable and o_valid does not drop.
  - o_valid never depends combinationally on i_ready.
- Boundaries:
  - Simultaneous push and pop on a full FIFO is illegal by construction (issue rule). The bench asserts no overflow.
  - H_ACTIVE=1: o_sof and o_eol on the same beat.
  - Final pixel carries eol and eof together.
  - Latency: first o_valid 3 cycles after the i_start edge (start -> FETCH, read issue, data pushed).
  - o_done asserts the cycle after FSM detects drained. It follows the final transfer by 2 cycles.

Decomposition:
- Shared package ps_stream_pkg:
  - FSM state encoding (IDLE/FETCH/DRAIN/DONE)
  - sideband bit positions in the FIFO word
- Sub-module: ps_stream_skid_fifo, a 2-deep first-word-fall-through FIFO with occ output. It is reusable by other stream sources.
- Raster counters and FSM remain in ps_frame_reader.

Test Plan:
- Use H_ACTIVE=4, V_ACTIVE=3, RAM preloaded with value=addr.
- Case 1: i_ready tied 1, pulse i_start.
  - 12 beats data 0..11 on consecutive cycles.
  - sof on 0; eol on 3,7,11; eof on 11.
  - o_done pulses once, 2 cycles after beat 11.
- Case 2: i_ready toggles 1,0,1,0 in the same setup.
  - Each stalled beat holds data and flags stable; the sequence is still 0..11.
  - No duplicates or drops; FIFO occ never exceeds 2.
- Case 3: i_ready low for 10 cycles after first o_valid.
  - At most 2 reads issued, then o_rd_en=0 until the stall releases.
  - Output resumes at 0,1,2...
- Case 4: assert i_rst during beat 5 with a read in flight.
  - Next cycle: all outputs 0, no o_done.
  - A new i_start produces a clean 0..11 frame.
- Case 5: pulse i_start again while busy.
  - Ignored: only one frame is produced and one o_done.
- Case 6: H_ACTIVE=1, V_ACTIVE=1.
  - Single beat data 0 with sof, eol and eof all set.
  - o_done follows.

Source files
------------

// File: rtl/ps_stream_pkg.sv
// Purpose : shared definitions for pixel-stream sources (FSM states, FIFO word layout).
// Latency : n/a (package only).
// Backpressure: n/a.
package ps_stream_pkg;

    // Frame reader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // Sideband bit positions in the low bits of a stream FIFO word.
    // The pixel occupies the bits above SB_W.
    localparam int SB_EOF = 0;
    localparam int SB_EOL = 1;
    localparam int SB_SOF = 2;
    localparam int SB_W   = 3;

endpackage

// File: rtl/ps_frame_reader_if.sv
// Purpose : valid/ready pixel stream with frame/line sideband.
// Latency : n/a (wires only).
// Backpressure: source holds data/valid/sideband while valid=1 and ready=0.
// Signals : data, valid, sof, eol, eof (source -> sink); ready (sink -> source).
interface ps_frame_reader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sof;
    logic              eol;
    logic              eof;

    modport master (output data, output valid, output sof, output eol, output eof,
                    input  ready);
    modport slave  (input  data, input  valid, input  sof, input  eol, input  eof,
                    output ready);
endinterface

// File: rtl/ps_stream_skid_fifo.sv
// Purpose : 2-deep first-word-fall-through FIFO for stream sources, exposes occupancy.
// Latency : push visible at the head on the next cycle.
// Backpressure: caller must not push into a full FIFO unless popping in the same cycle.
// Ports   : i_clk/i_rst (sync, active-high); i_push/i_push_dat write side;
//           i_pop read side; o_vld/o_dat head of queue; o_occ entries held (0..2).
module ps_stream_skid_fifo #(
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic [1:0]       o_occ
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q, occ_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = i_pop && (occ_q != 2'd0);
    // A push into a full FIFO is only accepted when the head leaves this cycle.
    assign push_ok = i_push && ((occ_q != 2'd2) || pop_ok);

    always_comb begin
        occ_d = occ_q;
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= i_push_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign o_vld = (occ_q != 2'd0);
    assign o_dat = mem_q[rd_ptr_q];
    assign o_occ = occ_q;
endmodule

// File: rtl/ps_frame_reader.sv
// Purpose : reads one raster-order frame from a 1-cycle-latency RAM onto a valid/ready stream.
// Latency : first o_strm.valid on the third clock edge counting the one that samples i_start.
// Backpressure: reads are throttled so issued-but-unconsumed pixels never exceed the 2-entry FIFO.
// Ports   : i_clk, i_rst (sync, active-high); i_start pulse, o_busy, o_done pulse;
//           o_rd_en/o_rd_addr/i_rd_data RAM read port; o_strm stream master with sof/eol/eof.
module ps_frame_reader
    import ps_stream_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                H_ACTIVE  = 640,
    parameter int                V_ACTIVE  = 480,
    parameter int                ADDR_W    = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    ps_frame_reader_if.master o_strm
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int FW = DATA_W + SB_W;

    rd_state_e         state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q;
    logic [SB_W-1:0]   sb_q;
    logic [SB_W-1:0]   sb_issue;

    logic              fifo_vld;
    logic [FW-1:0]     fifo_dat;
    logic [1:0]        fifo_occ;
    logic              pop;
    logic [2:0]        level;
    logic              issue;
    logic              x_last;
    logic              y_last;

    assign pop    = fifo_vld && o_strm.ready;
    assign x_last = (x_q == XW'(H_ACTIVE - 1));
    assign y_last = (y_q == YW'(V_ACTIVE - 1));

    // Pixels already owed to the FIFO (held + in flight). A slot freed by this
    // cycle's pop may be reused immediately, which keeps 1 pixel/clk at full rate.
    assign level = {1'b0, fifo_occ} + {2'b00, inflight_q};
    assign issue = (state_q == ST_FETCH) && (level < (3'd2 + {2'b00, pop}));

    always_comb begin
        sb_issue         = '0;
        sb_issue[SB_SOF] = (x_q == '0) && (y_q == '0);
        sb_issue[SB_EOL] = x_last;
        sb_issue[SB_EOF] = x_last && y_last;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (x_last) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                        if (y_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!fifo_vld && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= BASE_ADDR;
            inflight_q <= 1'b0;
            sb_q       <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            inflight_q <= issue;
            // Sideband rides alongside the read so it lands with the RAM data.
            if (issue) begin
                sb_q <= sb_issue;
            end
        end
    end

    ps_stream_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (inflight_q),
        .i_push_dat ({i_rd_data, sb_q}),
        .i_pop      (pop),
        .o_vld      (fifo_vld),
        .o_dat      (fifo_dat),
        .o_occ      (fifo_occ)
    );

    assign o_busy    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign o_done    = (state_q == ST_DONE);
    assign o_rd_en   = issue;
    assign o_rd_addr = addr_q;

    assign o_strm.valid = fifo_vld;
    assign o_strm.data  = fifo_dat[FW-1:SB_W];
    assign o_strm.sof   = fifo_dat[SB_SOF];
    assign o_strm.eol   = fifo_dat[SB_EOL];
    assign o_strm.eof   = fifo_dat[SB_EOF];
endmodule

// File: tb/tb_ps_frame_reader.sv
// Purpose : self-checking bench for ps_frame_reader (4x3 frame and 1x1 frame instances).
// Latency : n/a.
// Backpressure: ready patterns: always-on, toggling, long stall, random.
module tb_ps_frame_reader;
    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start1;
    logic        busy, done, rd_en;
    logic [18:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy1, done1, rd_en1;
    logic [18:0] rd_addr1;
    logic [7:0]  rd_data1;

    ps_frame_reader_if #(.DATA_W(8)) s0();
    ps_frame_reader_if #(.DATA_W(8)) s1();

    ps_frame_reader #(.DATA_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(19), .BASE_ADDR(19'd0)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_strm(s0));

    ps_frame_reader #(.DATA_W(8), .H_ACTIVE(1), .V_ACTIVE(1), .ADDR_W(19), .BASE_ADDR(19'd0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1), .o_strm(s1));

    // Framebuffers preloaded with value = address, 1-cycle read latency.
    always @(posedge clk) if (rd_en)  rd_data  <= rd_addr[7:0];
    always @(posedge clk) if (rd_en1) rd_data1 <= rd_addr1[7:0];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model state: expected beat index, counts and timing marks.
    int          ncyc, exp_idx, last_beat, done_cnt, issued, xfer, max_out, first_valid, start_cyc;
    logic        prev_stall;
    logic [10:0] prev_word;
    int          stall_left;
    bit          stall_used, stall_checked, tog;

    task automatic reset_model();
        ncyc = 0; exp_idx = 0; last_beat = -100; done_cnt = 0; issued = 0; xfer = 0;
        max_out = 0; first_valid = -1; prev_stall = 1'b0; prev_word = '0;
        stall_left = 0; stall_used = 1'b0; stall_checked = 1'b0; tog = 1'b1;
    endtask

    // Called once per cycle, after inputs for the cycle are settled, away from posedge.
    task automatic sample0();
        ncyc++;
        if (rd_en) issued++;
        if (s0.valid && s0.ready) xfer++;
        if (issued - xfer > max_out) max_out = issued - xfer;
        if (prev_stall) begin
            chk("stall_valid", int'(s0.valid), 1);
            chk("stall_hold", int'({s0.data, s0.sof, s0.eol, s0.eof}), int'(prev_word));
        end
        if (s0.valid && first_valid < 0) first_valid = ncyc;
        if (s0.valid && s0.ready) begin
            chk("beat_data", int'(s0.data), exp_idx);
            chk("beat_sof", int'(s0.sof), int'(exp_idx == 0));
            chk("beat_eol", int'(s0.eol), int'((exp_idx % H) == H - 1));
            chk("beat_eof", int'(s0.eof), int'(exp_idx == N - 1));
            if (exp_idx == N - 1) last_beat = ncyc;
            exp_idx++;
        end
        if (done) begin
            done_cnt++;
            chk("done_lat", ncyc - last_beat, 2);
            chk("busy_at_done", int'(busy), 0);
        end
        prev_stall = s0.valid && !s0.ready;
        prev_word  = {s0.data, s0.sof, s0.eol, s0.eof};
    endtask

    task automatic drive_ready(input int mode);
        case (mode)
            0: s0.ready = 1'b1;
            1: begin s0.ready = tog; tog = ~tog; end
            2: begin
                if (!stall_used && s0.valid) begin stall_left = 10; stall_used = 1'b1; end
                if (stall_left > 0) begin s0.ready = 1'b0; stall_left--; end
                else s0.ready = 1'b1;
            end
            default: s0.ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One frame on the 4x3 instance; extra_at>0 re-pulses i_start that many cycles in.
    task automatic run_frame(input int mode, input int extra_at);
        bit got_done;
        reset_model();
        got_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        drive_ready(mode);
        #1;
        start_cyc = ncyc + 1;
        sample0();
        chk("busy_idle", int'(busy), 0);
        for (int k = 0; k < 400 && !got_done; k++) begin
            @(negedge clk);
            start = (extra_at > 0 && ncyc + 1 == start_cyc + extra_at);
            drive_ready(mode);
            #1;
            sample0();
            if (ncyc == start_cyc + 1) chk("busy_rise", int'(busy), 1);
            if (mode == 2 && stall_used && stall_left == 0 && !stall_checked) begin
                stall_checked = 1'b1;
                chk("stall_reads", issued, 2);
            end
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        if (!got_done) chk("frame_timeout", 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s0.ready = 1'b1;
            #1;
            sample0();
        end
        chk("beat_count", exp_idx, N);
        chk("done_count", done_cnt, 1);
        chk("max_outstanding_le2", int'(max_out <= 2), 1);
        chk("first_valid_lat", first_valid - start_cyc, 3);
    endtask

    // Reset while beat 5 is presented at full rate (a read is in flight then).
    task automatic run_abort();
        bit hit;
        reset_model();
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        s0.ready = 1'b1;
        #1;
        sample0();
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (s0.valid && exp_idx == 5) hit = 1'b1;
            else sample0();
        end
        chk("abort_reached_beat5", int'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_valid", int'(s0.valid), 0);
        chk("rst_data", int'(s0.data), 0);
        chk("rst_flags", int'({s0.sof, s0.eol, s0.eof}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", int'(done), 0);
            chk("abort_no_valid", int'(s0.valid), 0);
        end
    endtask

    // Single-pixel frame on the 1x1 instance.
    task automatic run_single();
        int vcyc, c;
        bit seen, dseen;
        vcyc = 0; c = 0; seen = 1'b0; dseen = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        #1;
        for (int k = 0; k < 30 && !dseen; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            #1;
            c++;
            if (s1.valid && !seen) begin
                seen = 1'b1;
                vcyc = c;
                chk("one_data", int'(s1.data), 0);
                chk("one_flags", int'({s1.sof, s1.eol, s1.eof}), 7);
                chk("one_lat", c, 3);
            end
            if (done1) begin
                dseen = 1'b1;
                chk("one_done_lat", c - vcyc, 2);
            end
        end
        chk("one_seen", int'(seen), 1);
        chk("one_done_seen", int'(dseen), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        s0.ready = 1'b0; s1.ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", int'(s0.valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_data", int'({s0.data, s0.sof, s0.eol, s0.eof}), 0);
        rst = 1'b0;

        run_frame(0, 0);   // full rate
        run_frame(1, 0);   // ready toggling
        run_frame(2, 0);   // 10-cycle stall after first valid
        run_abort();       // reset mid-frame
        run_frame(0, 0);   // clean frame after abort
        run_frame(3, 4);   // random ready, extra start while busy
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(3, 0);
        end
        run_single();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
